// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// LSU_MISALIGN_SPLIT_EN adds the two extra states used to split misaligned halfwords.
package lsu_pkg;

    localparam int DEFAULT_MEM_BYTES = 64;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
`ifdef LSU_MISALIGN_SPLIT_EN
        , ACCESS_LO
        , WAIT_LO
`endif
    } lsu_state_t;

    // Range beats alignment; a misaligned halfword only faults when it cannot be split.
    function automatic logic [1:0] classify(input logic [15:0] addr, input logic half,
                                            input int mem_bytes, input logic split_en);
        logic [16:0] last_byte;
        last_byte = {1'b0, addr} + {16'd0, half};
        if (last_byte >= 17'(mem_bytes))
            return FAULT_RANGE;
        if (half && addr[0] && !split_en)
            return FAULT_MISALIGN;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load result formatting: halfwords pass through, bytes are sign- or zero-extended.
module lsu_load_extend (
    input  logic [15:0] raw,
    input  logic        half,
    input  logic        sign_ext,
    output logic [15:0] result
);

    logic fill;

    assign fill        = sign_ext & raw[7];
    assign result[7:0] = raw[7:0];

    generate
        for (genvar gi = 8; gi < 16; gi++) begin : g_upper
            assign result[gi] = half ? raw[gi] : fill;
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a big-endian byte memory with one-cycle registered reads.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned halfwords into two byte cycles.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_half,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic [1:0]  resp_fault,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_half,
    input  logic [15:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_t  state_reg, state_next;
    logic        we_reg, half_reg, sign_reg;
    logic [15:0] addr_reg, wdata_reg, data_reg;
    logic [1:0]  fault_reg;
    logic        accept;
    logic [1:0]  fault_now;
    logic        wide;
    logic [15:0] ext_raw, ext_result;
    logic        ext_half;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_reg;
    logic [7:0]  hi_reg;
`endif

    assign accept    = req_valid && (state_reg == IDLE);
    assign fault_now = classify(req_addr, req_half, MEM_BYTES, SPLIT_EN);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign wide     = half_reg && !split_reg;
    // The low-half read is merged with the captured high byte and treated as a halfword.
    assign ext_raw  = (state_reg == WAIT_LO) ? {hi_reg, mem_rdata[7:0]} : mem_rdata;
    assign ext_half = (state_reg == WAIT_LO) ? 1'b1 : half_reg;
`else
    assign wide     = half_reg;
    assign ext_raw  = mem_rdata;
    assign ext_half = half_reg;
`endif

    lsu_load_extend u_extend (
        .raw     (ext_raw),
        .half    (ext_half),
        .sign_ext(sign_reg),
        .result  (ext_result)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = (fault_now != FAULT_NONE) ? RESP : ACCESS;
            end
            ACCESS: begin
                if (!we_reg)
                    state_next = WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
                else if (split_reg)
                    state_next = ACCESS_LO;
`endif
                else
                    state_next = RESP;
            end
            WAIT: begin
                state_next = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_reg)
                    state_next = ACCESS_LO;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACCESS_LO: state_next = we_reg ? RESP : WAIT_LO;
            WAIT_LO:   state_next = RESP;
`endif
            RESP: begin
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            half_reg  <= 1'b0;
            sign_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            fault_reg <= FAULT_NONE;
            data_reg  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_reg <= 1'b0;
            hi_reg    <= '0;
`endif
        end else begin
            if (accept) begin
                we_reg    <= req_we;
                half_reg  <= req_half;
                sign_reg  <= req_signed;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                fault_reg <= fault_now;
                data_reg  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                split_reg <= req_half && req_addr[0];
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_reg == WAIT) begin
                if (split_reg)
                    hi_reg <= mem_rdata[7:0];
                else
                    data_reg <= ext_result;
            end
            if (state_reg == WAIT_LO)
                data_reg <= ext_result;
`else
            if (state_reg == WAIT)
                data_reg <= ext_result;
`endif
        end
    end

    always_comb begin
        req_ready  = (state_reg == IDLE);
        resp_valid = (state_reg == RESP);
        resp_data  = data_reg;
        resp_fault = fault_reg;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_half   = 1'b0;
        case (state_reg)
            ACCESS: begin
                mem_we    = we_reg;
                mem_addr  = addr_reg;
                mem_half  = wide;
                mem_wdata = wide ? wdata_reg : {8'h00, wdata_reg[7:0]};
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_reg)
                    mem_wdata = {8'h00, wdata_reg[15:8]};
`endif
            end
            WAIT: begin
                mem_addr = addr_reg;
                mem_half = wide;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACCESS_LO: begin
                mem_we    = we_reg;
                mem_addr  = addr_reg + 16'd1;
                mem_wdata = {8'h00, wdata_reg[7:0]};
            end
            WAIT_LO: begin
                mem_addr = addr_reg + 16'd1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-array memory model and a transaction-level reference.
module tb_mem_access_unit;

    localparam int MEMB = 64;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_half = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [1:0]  resp_fault;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_half;
    logic [15:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0] phys_mem [MEMB] = '{default: 8'h00};
    logic [7:0] ref_mem  [MEMB] = '{default: 8'h00};
    int         wr_count = 0;
    logic [5:0] ma0, ma1;

    logic [15:0] exp_data = '0;
    logic [1:0]  exp_fault = '0;
    bit          exp_we_ok = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEMB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_half  (req_half),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_fault(resp_fault),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_half  (mem_half),
        .mem_rdata (mem_rdata)
    );

    // Big-endian memory: lower address is the high byte; reads are registered.
    assign ma0 = mem_addr[5:0];
    assign ma1 = mem_addr[5:0] + 6'd1;
    always @(posedge clk) begin
        if (mem_we) begin
            wr_count <= wr_count + 1;
            if (mem_half) begin
                phys_mem[ma0] <= mem_wdata[15:8];
                phys_mem[ma1] <= mem_wdata[7:0];
            end else begin
                phys_mem[ma0] <= mem_wdata[7:0];
            end
        end
        mem_rdata <= mem_half ? {phys_mem[ma0], phys_mem[ma1]} : {8'h00, phys_mem[ma0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the whole transaction's outcome from the addressing rules.
    task automatic model(input bit we, input bit half, input bit sgn, input logic [15:0] addr,
                         input logic [15:0] wd, output logic [1:0] f, output logic [15:0] d,
                         output int lat, output int nwr);
        bit split;
        logic [7:0] b0, b1;
        d = 16'h0000; lat = 1; nwr = 0;
        if (addr >= 16'(MEMB) || (half && addr >= 16'(MEMB - 1)))
            f = 2'd2;
        else if (half && addr[0] && !SPLIT)
            f = 2'd1;
        else
            f = 2'd0;
        if (f != 2'd0)
            return;
        split = half && addr[0];
        if (we) begin
            if (half) begin
                ref_mem[addr] = wd[15:8];
                ref_mem[addr + 1] = wd[7:0];
            end else begin
                ref_mem[addr] = wd[7:0];
            end
            lat = split ? 3 : 2;
            nwr = split ? 2 : 1;
        end else begin
            b0 = ref_mem[addr];
            b1 = half ? ref_mem[addr + 1] : 8'h00;
            if (half)
                d = {b0, b1};
            else
                d = sgn ? {{8{b0[7]}}, b0} : {8'h00, b0};
            lat = split ? 5 : 3;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                check("resp_data", resp_data, exp_data);
                check("resp_fault", resp_fault, exp_fault);
            end
            if (!exp_we_ok)
                check("mem_we_quiet", mem_we, 1'b0);
        end
    end

    task automatic run_txn(input bit we, input bit half, input bit sgn, input logic [15:0] addr,
                           input logic [15:0] wd, input int hold,
                           output logic [15:0] got_data, output logic [1:0] got_fault, output int got_lat);
        logic [1:0]  ef;
        logic [15:0] ed, ewd;
        int elat, enwr, n, wr0, lat;
        model(we, half, sgn, addr, wd, ef, ed, elat, enwr);
        exp_data  = ed;
        exp_fault = ef;
        exp_we_ok = we && (ef == 2'd0);
        req_we = we; req_half = half; req_signed = sgn; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        wr0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (ef == 2'd0) begin
            check("access_addr", mem_addr, addr);
            check("access_we", mem_we, we);
            check("access_half", mem_half, half && !addr[0]);
            if (we) begin
                if (half && !addr[0]) ewd = wd;
                else if (half) ewd = {8'h00, wd[15:8]};
                else ewd = {8'h00, wd[7:0]};
                check("access_wdata", mem_wdata, ewd);
            end
        end
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, elat);
        got_data = resp_data;
        got_fault = resp_fault;
        got_lat = lat;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_data", resp_data, ed);
            check("hold_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("back_to_idle", {resp_valid, req_ready}, 2'b01);
        check("write_count", wr_count - wr0, enwr);
        exp_we_ok = 1'b0;
        $display("txn we=%0d half=%0d sgn=%0d addr=%0h wd=%0h -> data=%0h fault=%0d lat=%0d",
                 we, half, sgn, addr, wd, got_data, got_fault, got_lat);
    endtask

    initial begin
        logic [15:0] d;
        logic [1:0]  f;
        int          lat;
        bit          we, half, sgn;
        logic [15:0] addr;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, 16'h0);
        check("rst_resp_fault", resp_fault, 2'd0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_mem_half", mem_half, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1, 1, 0, 16'd4, 16'hA1B2, 0, d, f, lat);
        check("lit_hw_store_lat", lat, 2);
        run_txn(0, 1, 0, 16'd4, 16'h0000, 0, d, f, lat);
        check("lit_hw_load", d, 16'hA1B2);
        check("lit_hw_load_lat", lat, 3);

        run_txn(1, 0, 0, 16'd9, 16'h0085, 0, d, f, lat);
        run_txn(0, 0, 1, 16'd9, 16'h0000, 0, d, f, lat);
        check("lit_byte_signed", d, 16'hFF85);
        run_txn(0, 0, 0, 16'd9, 16'h0000, 0, d, f, lat);
        check("lit_byte_unsigned", d, 16'h0085);

        if (SPLIT) begin
            run_txn(1, 0, 0, 16'd7, 16'h0012, 0, d, f, lat);
            run_txn(1, 0, 0, 16'd8, 16'h0034, 0, d, f, lat);
            run_txn(0, 1, 0, 16'd7, 16'h0000, 0, d, f, lat);
            check("lit_split_load", d, 16'h1234);
            check("lit_split_lat", lat, 5);
        end else begin
            run_txn(0, 1, 0, 16'd7, 16'h0000, 0, d, f, lat);
            check("lit_misalign_fault", f, 2'd1);
            check("lit_misalign_lat", lat, 1);
        end

        run_txn(1, 0, 0, 16'd64, 16'h00EE, 0, d, f, lat);
        check("lit_range_store", f, 2'd2);
        run_txn(0, 1, 0, 16'd63, 16'h0000, 0, d, f, lat);
        check("lit_range_hw63", f, 2'd2);

        run_txn(0, 1, 0, 16'd4, 16'h0000, 10, d, f, lat);
        check("lit_hold_load", d, 16'hA1B2);

        // Reset landing on the ACCESS edge of a store: the write still happens.
        exp_we_ok = 1'b1;
        exp_data = '0;
        exp_fault = '0;
        req_we = 1; req_half = 0; req_signed = 0; req_addr = 16'd20; req_wdata = 16'h005A;
        req_valid = 1'b1;
        check("rst_test_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_test_access_we", mem_we, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        ref_mem[20] = 8'h5A;
        @(negedge clk);
        check("rst_test_idle", req_ready, 1'b1);
        check("rst_test_no_resp", resp_valid, 1'b0);
        check("rst_test_we_low", mem_we, 1'b0);
        rst = 1'b0;
        exp_we_ok = 1'b0;
        @(negedge clk);
        run_txn(0, 0, 0, 16'd20, 16'h0000, 0, d, f, lat);
        check("lit_rst_store_kept", d, 16'h005A);

        for (int t = 0; t < 250; t++) begin
            we   = 1'($urandom_range(0, 1));
            half = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 69));
            if ($urandom_range(0, 24) == 0)
                addr = 16'hFFF0 | 16'($urandom_range(0, 15));
            run_txn(we, half, sgn, addr, 16'($urandom), $urandom_range(0, 3), d, f, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the execute stage and the 64-byte data memory. It accepts one byte or halfword load/store request per transaction over a valid/ready handshake and checks alignment and range. It drives the memory's write-enable, address, write data and size-select, then returns sign- or zero-extended load data on a held response channel. The memory is big-endian: the lower address holds the high byte. The memory has registered reads (one-cycle latency).

## Interface
- MEM_BYTES, 64, addressable bytes; legal byte addresses are 0..MEM_BYTES-1.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept.
- req_we  in  1  1 = store, 0 = load.
- req_half  in  1  1 = halfword, 0 = byte.
- req_signed  in  1  byte load: sign-extend when 1, zero-extend when 0.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; a byte store uses [7:0].
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  16  load result; 0 for stores and faults.
- resp_fault  out  2  0 ok, 1 misaligned, 2 out-of-range.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_half  out  1  memory size-select: 1 = two bytes, 0 = one byte.
- mem_rdata  in  16  memory read data, valid the cycle after the address is presented with mem_we=0.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. With LSU_MISALIGN_SPLIT_EN, add ACCESS_LO and WAIT_LO.
- IDLE:
  - req_ready=1.
  - When req_valid&&req_ready at an edge, register the request and run the checks below.
- Checks, in priority order:
  - Out-of-range: req_addr ≥ MEM_BYTES, or for a halfword req_addr+1 ≥ MEM_BYTES. Fault code 2.
  - Misaligned: halfword with req_addr[0]=1. Fault code 1, unless split is enabled.
  - A faulting request goes straight to RESP. No memory cycle is issued and mem_we stays 0.
- ACCESS:
  - Drive mem_addr, mem_half and mem_wdata from the registered request.
  - mem_we=req_we.
  - Store: go to RESP.
  - Load: go to WAIT.
- WAIT:
  - mem_we=0, mem_addr held.
  - Capture mem_rdata.
  - Byte load: result is mem_rdata[7:0], extended to 16 bits per req_signed.
  - Halfword load: result is mem_rdata[15:0].
  - Go to RESP.
- RESP:
  - resp_valid=1 with stable resp_data and resp_fault.
  - When resp_ready=1 at an edge, go to IDLE.
- mem_we is 1 only in ACCESS/ACCESS_LO states of a store. mem_* outputs are decoded from registered state only.

## Timing
- Reset values:
  - State is IDLE.
  - req_ready=1 during the IDLE cycle after reset.
  - resp_valid=0, resp_data=0, resp_fault=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_half=0.
- Latency, with the accept edge as cycle 0:
  - Store: ACCESS in cycle 1, resp_valid in cycle 2.
  - Load: ACCESS in cycle 1, WAIT in cycle 2, resp_valid in cycle 3.
  - Fault: resp_valid in cycle 1.
- Back-to-back: the response-accept edge returns to IDLE. The next request can be accepted one cycle later, so throughput is at most 1 per 3 cycles for stores.
- resp_ready held low: RESP persists indefinitely and req_ready stays 0.
- Reset mid-operation: any state returns to IDLE at the reset edge and the pending response is dropped. A store whose ACCESS cycle coincides with the reset edge is still written, because the memory samples mem_we on the same edge.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - A misaligned in-range halfword is split into two byte cycles, with no fault.
  - ACCESS (hi): byte at addr, mem_half=0. A store drives mem_wdata={8'h00, wdata[15:8]}.
  - Load only: WAIT captures the high byte.
  - ACCESS_LO: byte at addr+1. A store drives mem_wdata={8'h00, wdata[7:0]}.
  - Load only: WAIT_LO captures the low byte.
  - Then RESP. Load result is {hi, lo}.
  - Store latency 3 cycles, load latency 5 cycles.
  - Reset between the two halves leaves only the high byte written.
- Undefined: a misaligned halfword faults with code 1. ACCESS_LO and WAIT_LO do not exist.

## Structure
- Package lsu_pkg holds:
  - state enum.
  - fault codes FAULT_NONE=0, FAULT_MISALIGN=1, FAULT_RANGE=2.
  - default MEM_BYTES.
- Sub-module lsu_load_extend: a combinational unit taking raw byte or halfword, req_half and req_signed, and producing the 16-bit result. Shared by the WAIT and WAIT_LO paths.

## Test plan
- Halfword store 16'hA1B2 to addr 4, then halfword load from addr 4:
  - Store: mem_we pulses 1 cycle with mem_addr=4, mem_half=1.
  - Load: resp_data=16'hA1B2, resp_fault=0, resp_valid 3 cycles after accept.
- Byte store 8'h85 to addr 9, then byte loads from addr 9:
  - Signed load returns 16'hFF85.
  - Unsigned load returns 16'h0085.
- Halfword load from addr 7, split undefined: resp_fault=1 one cycle after accept, mem_we never 1.
- Same halfword load from addr 7 with the macro defined, after bytes 7=8'h12 and 8=8'h34: resp_data=16'h1234 in 5 cycles.
- Out-of-range accesses:
  - Byte store to addr 64: resp_fault=2, no write.
  - Halfword load from addr 63: resp_fault=2.
- Load with resp_ready held low for 10 cycles:
  - resp_valid and resp_data stay stable, req_ready=0.
  - Assert rst in ACCESS of a following store: IDLE next cycle, resp_valid=0.
